// File: rtl/alien_bomb_scheduler_if.sv
// Launch/retire bus between the bomb scheduler (master) and the bank of bomb datapaths (slave).
// Launch fields are meaningful only while launch is high.
interface alien_bomb_scheduler_if #(
    parameter int MAX_BOMBS = 2
);
    logic                 launch;
    logic [2:0]           launch_slot;
    logic [3:0]           launch_col;
    logic [1:0]           launch_row;
    logic [MAX_BOMBS-1:0] slots_busy;
    logic [MAX_BOMBS-1:0] bomb_done;

    modport master (
        output launch,
        output launch_slot,
        output launch_col,
        output launch_row,
        output slots_busy,
        input  bomb_done
    );

    modport slave (
        input  launch,
        input  launch_slot,
        input  launch_col,
        input  launch_row,
        input  slots_busy,
        output bomb_done
    );
endinterface

// File: rtl/alien_bomb_scheduler.sv
// Chooses when the alien formation drops a bomb, from which column and row, and into which free slot.
// A frame counter paces attempts, an LFSR picks the starting column, and a column scan finds a live shooter.
module alien_bomb_scheduler #(
    parameter int NUM_ROWS      = 3,
    parameter int NUM_COLS      = 5,
    parameter int MAX_BOMBS     = 2,
    parameter int FIRE_INTERVAL = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_tick,
    input  logic                         enable,
    input  logic [NUM_ROWS*NUM_COLS-1:0] alive_matrix,
    alien_bomb_scheduler_if.master       bomb
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LAUNCH
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [3:0]           cur_col_q, cur_col_d;
    logic [4:0]           step_q, step_d;
    logic                 launch_q, launch_d;
    logic [2:0]           slot_q, slot_d;
    logic [3:0]           col_q, col_d;
    logic [1:0]           row_q, row_d;
    logic [MAX_BOMBS-1:0] busy_q, busy_d;

    logic [3:0]           start_col;
    logic [NUM_ROWS-1:0]  cur_col_bits;
    logic                 col_alive;
    logic [1:0]           hit_row;
    logic [2:0]           free_slot;
    logic                 any_free;

    assign start_col = 4'(lfsr_q % 8'(NUM_COLS));
    assign col_alive = |cur_col_bits;
    assign any_free  = ~&busy_q;

    // Gather the column under test; the last live row found is the lowest alien on screen.
    always_comb begin
        cur_col_bits = '0;
        hit_row      = '0;
        free_slot    = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (cur_col_q == 4'(c)) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    cur_col_bits[r] = alive_matrix[r*NUM_COLS + c];
                end
            end
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (cur_col_bits[r]) begin
                hit_row = 2'(r);
            end
        end
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_slot = 3'(i);
            end
        end
    end

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        busy_d = busy_q & ~bomb.bomb_done;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (launch_q && slot_q == 3'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_col_d = cur_col_q;
        step_d    = step_q;
        launch_d  = 1'b0;
        slot_d    = slot_q;
        col_d     = col_q;
        row_d     = row_q;

        if (frame_tick && enable && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (cnt_q == 8'd0 && enable && any_free) begin
                    state_d   = SEARCH;
                    cur_col_d = start_col;
                    step_d    = '0;
                end
            end
            SEARCH: begin
                // Dropping enable abandons the search but leaves the counter at zero so it resumes promptly.
                if (!enable) begin
                    state_d = IDLE;
                end else if (col_alive) begin
                    state_d  = LAUNCH;
                    launch_d = 1'b1;
                    slot_d   = free_slot;
                    col_d    = cur_col_q;
                    row_d    = hit_row;
                end else if (step_q == 5'(NUM_COLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 8'(FIRE_INTERVAL);
                end else begin
                    cur_col_d = (cur_col_q == 4'(NUM_COLS - 1)) ? 4'd0 : cur_col_q + 4'd1;
                    step_d    = step_q + 5'd1;
                end
            end
            LAUNCH: begin
                state_d = IDLE;
                cnt_d   = 8'(FIRE_INTERVAL);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'(FIRE_INTERVAL);
            lfsr_q    <= 8'hA5;
            cur_col_q <= '0;
            step_q    <= '0;
            launch_q  <= 1'b0;
            slot_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            cur_col_q <= cur_col_d;
            step_q    <= step_d;
            launch_q  <= launch_d;
            slot_q    <= slot_d;
            col_q     <= col_d;
            row_q     <= row_d;
            busy_q    <= busy_d;
        end
    end

    assign bomb.launch      = launch_q;
    assign bomb.launch_slot = slot_q;
    assign bomb.launch_col  = col_q;
    assign bomb.launch_row  = row_q;
    assign bomb.slots_busy  = busy_q;

endmodule

// File: doc/alien_bomb_scheduler.md
# alien_bomb_scheduler

Decides when the alien formation drops a bomb, which column drops it, and which bomb slot carries it. Sits between the alien formation (live-alien map) and a bank of MAX_BOMBS bomb datapaths. Paced by frame ticks derived from vsync; runs on the pixel clock. Each bomb datapath reports back when its bomb leaves the screen or hits something.

## Interface
Parameters:
- NUM_ROWS, 3, formation rows; row 0 is the top row.
- NUM_COLS, 5, formation columns, range 1..16.
- MAX_BOMBS, 2, concurrent bomb slots, range 1..8.
- FIRE_INTERVAL, 40, frames between launch attempts, range 1..255.

Ports:
- clk, in, 1, pixel clock (25 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- frame_tick, in, 1, one-clk pulse per frame, synchronous to clk.
- enable, in, 1, gameplay active.
- alive_matrix, in, NUM_ROWS*NUM_COLS, bit r*NUM_COLS+c is 1 when the alien at row r, column c is alive.
- bomb_done, in, MAX_BOMBS, one-clk pulse per slot when that bomb retires.
- launch, out, 1, one-clk pulse that starts a bomb.
- launch_slot, out, 3, slot index to start; valid while launch is 1.
- launch_col, out, 4, firing column; valid while launch is 1.
- launch_row, out, 2, row of the firing alien; valid while launch is 1.
- slots_busy, out, MAX_BOMBS, occupancy bit per slot.

## Operation
Frame counter (8 bit):
- Reset value is FIRE_INTERVAL.
- Decrements on frame_tick while enable=1 and the counter is greater than 0.
- Holds at 0 until a search begins.
- Reloads to FIRE_INTERVAL on entry to IDLE from LAUNCH or from an unsuccessful SEARCH.

LFSR (8 bit):
- Polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset.
- Advances every clk, regardless of enable.
- start_col = lfsr % NUM_COLS.

State machine, three states:
- IDLE: moves to SEARCH when counter==0, enable=1 and at least one slot is free. On that move, latches start_col into cur_col and clears step.
- SEARCH: each cycle tests column cur_col for any alive bit.
  - Hit: latch cur_col, latch the highest alive row index in that column (the lowest alien on screen), latch the lowest-index free slot, then go to LAUNCH.
  - Miss: cur_col = (cur_col+1) wrapping at NUM_COLS, and step+1.
  - After NUM_COLS misses (formation empty): go to IDLE with counter reloaded and no launch.
- LAUNCH: launch=1 for exactly this cycle with the latched slot, column and row. Sets slots_busy[slot]. Next state is IDLE.

Slot tracking:
- bomb_done[i] clears slots_busy[i].
- bomb_done on a slot that is already free is ignored.
- A set and a clear on different slots in the same cycle both take effect.
- A clear and a set on the same slot cannot occur, because only free slots are launched.

Other rules:
- enable=0 during SEARCH: return to IDLE, no launch, counter unchanged (stays 0).
- enable=0 during LAUNCH: the launch still completes.
- All slots busy with counter==0: wait in IDLE. The search starts the cycle after a slot frees.
- Reset mid-operation: state=IDLE, counter=FIRE_INTERVAL, lfsr=8'hA5, slots_busy=0, launch=0, launch_slot/launch_col/launch_row=0. Any bomb in flight is forgotten.

## Timing
- All outputs are registered. launch_slot, launch_col and launch_row change only on entry to LAUNCH.
- Latency from the counter reaching 0 to launch:
  - 3 cycles when start_col is alive (IDLE → SEARCH → LAUNCH).
  - Worst case NUM_COLS+2 cycles.
- slots_busy updates on the clk edge that ends the LAUNCH cycle, and on the edge after a bomb_done pulse.
- frame_tick arriving during SEARCH or LAUNCH has no effect: the counter is 0 and holding.

## Test plan
- Reset then enable=1, FIRE_INTERVAL=3, all aliens alive, 3 frame_ticks → exactly one launch pulse within 7 clks of the 3rd tick, launch_slot=0, launch_row=2, slots_busy=01.
- alive_matrix has only row 1, column 3 set → every launch has launch_col=3 and launch_row=1, for 16 launches across differing LFSR states.
- MAX_BOMBS=2 with no bomb_done → two launches (slots 0 then 1), then none through 5 more intervals. Pulse bomb_done=10 → next launch uses slot 1 within 3 clks.
- alive_matrix=0 → no launch ever. The counter reloads and the search repeats every FIRE_INTERVAL frames, taking NUM_COLS cycles each time.
- Drop enable in the SEARCH cycle → no launch and state IDLE. Reassert enable → launch within NUM_COLS+2 clks without further frame_ticks.
- Assert rst_n=0 during LAUNCH with slots_busy=01 → all outputs 0 and slots_busy=00 immediately. The first launch after release needs a full FIRE_INTERVAL frames.
